// File: rtl/vga_sprite_pkg.sv
// vga_sprite_pkg: shared types, register map, reset defaults and RGB565 expansion for the sprite compositor
package vga_sprite_pkg;
  typedef logic [15:0] rgb565_t;
  localparam int CTRL_EN = 0;
  localparam int CTRL_HFLIP = 1;
  localparam logic [8:0] REG_BG = 9'h100;
  localparam logic [8:0] REG_KEY = 9'h101;
  localparam int CH_STRIDE = 4;
  localparam rgb565_t BG_RST = 16'hFFFF;
  localparam rgb565_t KEY_RST = 16'hF81F;
  function automatic logic [23:0] rgb565_to_rgb888(input rgb565_t d);
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
  endfunction
endpackage

// File: rtl/sprite_channel.sv
// sprite_channel: one sprite's pending/active X,Y,CTRL, hit test and registered ROM address; ports clk/reset, i_we_x/y/ctrl+i_wdata writes, i_commit, i_px/i_vcount in, o_rom_addr/o_hit out
module sprite_channel
  import vga_sprite_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    i_we_x,
  input  logic                                    i_we_y,
  input  logic                                    i_we_ctrl,
  input  logic [9:0]                              i_wdata,
  input  logic                                    i_commit,
  input  logic [9:0]                              i_px,
  input  logic [9:0]                              i_vcount,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]    o_rom_addr,
  output logic                                    o_hit
);
  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  logic [9:0] r_x_p, r_y_p, r_x_a, r_y_a;
  logic [1:0] r_ctrl_p, r_ctrl_a;
  logic w_hit;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  assign w_hit = r_ctrl_a[CTRL_EN]
    && {1'b0, i_px} >= {1'b0, r_x_a} && {1'b0, i_px} < {1'b0, r_x_a} + 11'(SPRITE_W)
    && {1'b0, i_vcount} >= {1'b0, r_y_a} && {1'b0, i_vcount} < {1'b0, r_y_a} + 11'(SPRITE_H);
  assign w_col = r_ctrl_a[CTRL_HFLIP] ? ~CW'(i_px - r_x_a) : CW'(i_px - r_x_a);
  assign w_row = RW'(i_vcount - r_y_a);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x_p <= '0;
      r_y_p <= '0;
      r_ctrl_p <= '0;
      r_x_a <= '0;
      r_y_a <= '0;
      r_ctrl_a <= '0;
      o_rom_addr <= '0;
      o_hit <= 1'b0;
    end else begin
      if (i_commit) begin
        r_x_a <= r_x_p;
        r_y_a <= r_y_p;
        r_ctrl_a <= r_ctrl_p;
      end
      if (i_we_x) r_x_p <= i_wdata;
      if (i_we_y) r_y_p <= i_wdata;
      if (i_we_ctrl) r_ctrl_p <= i_wdata[1:0];
      o_rom_addr <= w_hit ? {w_row, w_col} : '0;
      o_hit <= w_hit;
    end
  end
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: N-channel priority sprite mixer; ports clk/reset, Avalon write (chipselect/write/address/writedata), hcount/vcount/blank_n, rom_addr/rom_data, vga_r/g/b, frame_commit
module sprite_compositor
  import vga_sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 6,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int HACTIVE = 1280,
  parameter int VACTIVE = 480
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                chipselect,
  input  logic                                                write,
  input  logic [8:0]                                          address,
  input  logic [31:0]                                         writedata,
  input  logic [10:0]                                         hcount,
  input  logic [9:0]                                          vcount,
  input  logic                                                blank_n,
  output logic [NUM_SPRITES*$clog2(SPRITE_W*SPRITE_H)-1:0]    rom_addr,
  input  logic [NUM_SPRITES*16-1:0]                           rom_data,
  output logic [7:0]                                          vga_r,
  output logic [7:0]                                          vga_g,
  output logic [7:0]                                          vga_b,
  output logic                                                frame_commit
);
  localparam int AW = $clog2(SPRITE_W*SPRITE_H);
  localparam int SW = $clog2(CH_STRIDE);
  logic w_wr, w_chan_wr, w_commit, w_unused;
  logic [9:0] w_px;
  logic [7-SW:0] w_ch;
  logic [SW-1:0] w_off;
  logic [NUM_SPRITES-1:0] w_hit;
  rgb565_t w_pix;
  rgb565_t r_bg, r_key;
  logic [NUM_SPRITES-1:0] r_hit_d;
  logic [1:0] r_blank;
  logic [23:0] r_rgb;
  logic r_commit;
  assign w_wr = chipselect && write;
  assign w_chan_wr = w_wr && !address[8];
  assign w_ch = address[7:SW];
  assign w_off = address[SW-1:0];
  assign w_px = hcount[$clog2(HACTIVE)-1:1];
  assign w_commit = hcount == '0 && vcount == 10'(VACTIVE);
  assign w_unused = ^writedata[31:16];
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
    logic w_sel;
    assign w_sel = w_chan_wr && w_ch == (8-SW)'(i);
    sprite_channel #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_ch (
      .clk(clk),
      .reset(reset),
      .i_we_x(w_sel && w_off == SW'(0)),
      .i_we_y(w_sel && w_off == SW'(1)),
      .i_we_ctrl(w_sel && w_off == SW'(2)),
      .i_wdata(writedata[9:0]),
      .i_commit(w_commit),
      .i_px(w_px),
      .i_vcount(vcount),
      .o_rom_addr(rom_addr[i*AW +: AW]),
      .o_hit(w_hit[i])
    );
  end
  // descending scan so the lowest-index opaque channel is the last to claim the pixel
  always_comb begin
    w_pix = r_bg;
    for (int k = NUM_SPRITES - 1; k >= 0; k--)
      w_pix = r_hit_d[k] && rom_data[k*16 +: 16] != r_key ? rom_data[k*16 +: 16] : w_pix;
  end
  // rom_addr and hit register together; ROM data and the delayed hit/blank meet one clock later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bg <= BG_RST;
      r_key <= KEY_RST;
      r_hit_d <= '0;
      r_blank <= '0;
      r_rgb <= '0;
      r_commit <= 1'b0;
    end else begin
      if (w_wr && address == REG_BG) r_bg <= writedata[15:0];
      if (w_wr && address == REG_KEY) r_key <= writedata[15:0];
      r_hit_d <= w_hit;
      r_blank <= {r_blank[0], blank_n};
      r_rgb <= r_blank[1] ? rgb565_to_rgb888(w_pix) : '0;
      r_commit <= w_commit;
    end
  end
  assign {vga_r, vga_g, vga_b} = r_rgb;
  assign frame_commit = r_commit;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: table, directed and randomized checks of sprite_compositor against a behavioural model
module tb_sprite_compositor;
  localparam int NS = 6, SW = 32, SH = 32, AW = 10;
  logic clk = 0, reset = 1, chipselect = 0, write = 0, blank_n = 0;
  logic [8:0] address = '0;
  logic [31:0] writedata = '0;
  logic [10:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic [NS*AW-1:0] rom_addr;
  logic [NS*16-1:0] rom_data = '0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic frame_commit;
  sprite_compositor #(.NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH), .HACTIVE(1280), .VACTIVE(480)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .hcount(hcount), .vcount(vcount), .blank_n(blank_n),
    .rom_addr(rom_addr), .rom_data(rom_data), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_commit(frame_commit)
  );
  always #10 clk = ~clk;
  logic [15:0] rom_mem [NS][SW*SH];
  always @(posedge clk)
    for (int k = 0; k < NS; k++) rom_data[k*16 +: 16] <= rom_mem[k][rom_addr[k*AW +: AW]];
  int x_p[NS], y_p[NS], en_p[NS], fl_p[NS];
  int x_a[NS], y_a[NS], en_a[NS], fl_a[NS];
  int bg, key;
  logic [23:0] h_rgb[3];
  bit h_ok[3];
  int total = 0, bad = 0;
  typedef struct { int hc; int vc; bit bl; logic [23:0] rgb; } vec_t;
  function automatic logic [23:0] to888(int c);
    int r = (c >> 11) & 31, g = (c >> 5) & 63, b = c & 31;
    return 24'(((r * 8 + r / 4) << 16) | ((g * 4 + g / 16) << 8) | (b * 8 + b / 4));
  endfunction
  function automatic bit m_hit(int ch, int hc, int vc);
    int px = hc / 2;
    return en_a[ch] != 0 && px >= x_a[ch] && px < x_a[ch] + SW && vc >= y_a[ch] && vc < y_a[ch] + SH;
  endfunction
  function automatic int m_addr(int ch, int hc, int vc);
    int col = hc / 2 - x_a[ch];
    if (!m_hit(ch, hc, vc)) return 0;
    if (fl_a[ch] != 0) col = SW - 1 - col;
    return (vc - y_a[ch]) * SW + col;
  endfunction
  function automatic logic [23:0] m_rgb(int hc, int vc, bit bl);
    if (!bl) return 24'h0;
    for (int ch = 0; ch < NS; ch++)
      if (m_hit(ch, hc, vc) && int'(rom_mem[ch][m_addr(ch, hc, vc)]) != key)
        return to888(int'(rom_mem[ch][m_addr(ch, hc, vc)]));
    return to888(bg);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic flush;
    for (int k = 0; k < 3; k++) h_ok[k] = 0;
  endtask
  task automatic model_reset;
    for (int k = 0; k < NS; k++) begin
      x_p[k] = 0; y_p[k] = 0; en_p[k] = 0; fl_p[k] = 0;
      x_a[k] = 0; y_a[k] = 0; en_a[k] = 0; fl_a[k] = 0;
    end
    bg = 'hFFFF;
    key = 'hF81F;
    flush();
  endtask
  task automatic cycle(input int hc, input int vc, input bit bl, input bit wr, input int adr, input int dat);
    int ea[NS];
    bit ec;
    hcount = 11'(hc); vcount = 10'(vc); blank_n = bl;
    chipselect = wr; write = wr; address = 9'(adr); writedata = dat;
    for (int k = 0; k < NS; k++) ea[k] = m_addr(k, hc, vc);
    ec = hc == 0 && vc == 480;
    h_rgb[2] = h_rgb[1]; h_ok[2] = h_ok[1];
    h_rgb[1] = h_rgb[0]; h_ok[1] = h_ok[0];
    h_rgb[0] = m_rgb(hc, vc, bl); h_ok[0] = 1;
    @(posedge clk); #1;
    for (int k = 0; k < NS; k++) chk($sformatf("rom_addr[%0d]", k), 32'(rom_addr[k*AW +: AW]), ea[k]);
    chk("frame_commit", 32'(frame_commit), 32'(ec));
    if (h_ok[2]) chk("rgb", {8'h0, vga_r, vga_g, vga_b}, {8'h0, h_rgb[2]});
    if (ec) begin
      x_a = x_p; y_a = y_p; en_a = en_p; fl_a = fl_p;
    end
    if (wr) begin
      if (adr == 256 || adr == 257) begin
        if (adr == 256) bg = dat & 'hFFFF; else key = dat & 'hFFFF;
        h_ok[0] = 0; h_ok[1] = 0;
      end else if (adr < 256 && adr / 4 < NS) begin
        if (adr % 4 == 0) x_p[adr / 4] = dat & 1023;
        if (adr % 4 == 1) y_p[adr / 4] = dat & 1023;
        if (adr % 4 == 2) begin en_p[adr / 4] = dat & 1; fl_p[adr / 4] = (dat >> 1) & 1; end
      end
    end
  endtask
  task automatic go(input int hc, input int vc);
    cycle(hc, vc, 1, 0, 0, 0);
  endtask
  task automatic hold(input int hc, input int vc, input int n);
    repeat (n) go(hc, vc);
  endtask
  task automatic wr(input int adr, input int dat);
    cycle(300, 200, 1, 1, adr, dat);
  endtask
  task automatic commit_frame;
    cycle(0, 480, 0, 0, 0, 0);
  endtask
  task automatic do_reset(input int n);
    reset = 1; chipselect = 0; write = 0;
    @(posedge clk); #1;
    chk("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 0);
    chk("rst_commit", 32'(frame_commit), 0);
    chk("rst_addr", 32'(rom_addr != '0), 0);
    repeat (n) begin @(posedge clk); #1; end
    model_reset();
    reset = 0;
  endtask
  function automatic logic [23:0] rgb_now();
    return {vga_r, vga_g, vga_b};
  endfunction
  initial begin
    vec_t vt[5];
    int r, ch, px, hc, vc, adr, dat;
    for (int c = 0; c < NS; c++)
      for (int a = 0; a < SW * SH; a++) rom_mem[c][a] = 16'($urandom);
    rom_mem[0][0] = 16'h1234;
    model_reset();
    do_reset(3);
    vt[0] = '{300, 100, 1, 24'hFFFFFF};
    vt[1] = '{0, 480, 0, 24'h000000};
    vt[2] = '{1279, 479, 1, 24'hFFFFFF};
    vt[3] = '{1300, 10, 0, 24'h000000};
    vt[4] = '{0, 0, 1, 24'hFFFFFF};
    foreach (vt[i]) begin
      repeat (4) cycle(vt[i].hc, vt[i].vc, vt[i].bl, 0, 0, 0);
      chk("tbl_rgb", {8'h0, rgb_now()}, {8'h0, vt[i].rgb});
      chk("tbl_addr", 32'(rom_addr != '0), 0);
    end
    wr(0, 100); wr(1, 50); wr(2, 1);
    hold(200, 50, 4);
    chk("pre_commit_addr", 32'(rom_addr[0 +: AW]), 0);
    chk("pre_commit_rgb", {8'h0, rgb_now()}, 32'hFFFFFF);
    commit_frame();
    chk("commit_pulse", 32'(frame_commit), 1);
    go(2, 480);
    chk("commit_one_shot", 32'(frame_commit), 0);
    go(200, 50);
    chk("ch0_origin_addr", 32'(rom_addr[0 +: AW]), 0);
    go(400, 300); go(400, 300);
    chk("ch0_rgb_lat2", {8'h0, rgb_now()}, {8'h0, to888('h1234)});
    wr(4, 100); wr(5, 50); wr(6, 1);
    rom_mem[0][0] = 16'hF81F; rom_mem[1][0] = 16'h001F; flush();
    commit_frame();
    hold(200, 50, 4);
    chk("overlap_key", {8'h0, rgb_now()}, 32'h0000FF);
    rom_mem[0][0] = 16'hF800; flush();
    hold(200, 50, 4);
    chk("overlap_prio", {8'h0, rgb_now()}, 32'hFF0000);
    wr(8, 10); wr(9, 0); wr(10, 3);
    rom_mem[2][0] = 16'h07FF; flush();
    commit_frame();
    go(20, 0);
    chk("hflip_left", 32'(rom_addr[2*AW +: AW]), 31);
    hold(82, 0, 3);
    chk("hflip_right", 32'(rom_addr[2*AW +: AW]), 0);
    chk("hflip_right_rgb", {8'h0, rgb_now()}, 32'h00FFFF);
    hold(84, 0, 4);
    chk("hflip_past", 32'(rom_addr[2*AW +: AW]), 0);
    chk("hflip_past_rgb", {8'h0, rgb_now()}, 32'hFFFFFF);
    cycle(0, 480, 0, 1, 0, 300);
    chk("commit_write_pulse", 32'(frame_commit), 1);
    go(202, 50);
    chk("old_x_kept", 32'(rom_addr[0 +: AW]), 1);
    go(602, 50);
    chk("new_x_not_yet", 32'(rom_addr[0 +: AW]), 0);
    commit_frame();
    go(602, 50);
    chk("new_x_applied", 32'(rom_addr[0 +: AW]), 1);
    go(202, 50);
    chk("old_x_gone", 32'(rom_addr[0 +: AW]), 0);
    wr(10, 0); wr(12, 630); wr(13, 0); wr(14, 1); wr(256, 'h07E0);
    commit_frame();
    for (int h = 0; h < 1280; h++) go(h, 5);
    go(1278, 5);
    chk("clip_last", 32'(rom_addr[3*AW +: AW]), 169);
    go(1258, 5);
    chk("clip_before", 32'(rom_addr[3*AW +: AW]), 0);
    hold(10, 5, 4);
    chk("clip_no_wrap", 32'(rom_addr[3*AW +: AW]), 0);
    chk("clip_bg_green", {8'h0, rgb_now()}, 32'h00FF00);
    for (int c = 0; c < NS; c++)
      for (int a = 0; a < SW * SH; a++)
        rom_mem[c][a] = $urandom_range(0, 3) == 0 ? 16'(key) : 16'($urandom);
    flush();
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        do_reset($urandom_range(0, 2));
      end else if (r < 18) begin
        adr = $urandom_range(0, 9) < 7 ? $urandom_range(0, 31) :
              $urandom_range(0, 2) == 0 ? $urandom_range(256, 257) : $urandom_range(0, 511);
        dat = (adr % 4 == 2) ? int'($urandom) : int'(($urandom & 32'hFFFF_FC00) | $urandom_range(0, 700));
        cycle($urandom_range(0, 1599), $urandom_range(0, 524), 1, 1, adr, dat);
      end else if (r < 30) begin
        commit_frame();
      end else begin
        if (r < 130) begin
          ch = $urandom_range(0, NS - 1);
          px = x_a[ch] + $urandom_range(0, SW + 3) - 2;
          hc = px < 0 ? 0 : px * 2 + $urandom_range(0, 1);
          vc = y_a[ch] + $urandom_range(0, SH + 3) - 2;
          hc = hc > 2047 ? 2047 : hc;
          vc = vc < 0 ? 0 : vc > 1023 ? 1023 : vc;
        end else begin
          hc = $urandom_range(0, 1599);
          vc = $urandom_range(0, 524);
        end
        cycle(hc, vc, $urandom_range(0, 4) != 0, 0, 0, 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
